// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one single-port video memory between the scan
// reader (fixed priority, fixed 1-cycle latency), a clear engine that fills
// the whole memory with one value, and a valid/ready host write port.
module vram_port_arbiter #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic [DW-1:0] disp_rdata,
   output logic          disp_rvalid,
   input  logic          wr_valid,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   input  logic          clr_start,
   input  logic [DW-1:0] clr_data,
   output logic          clr_busy,
   output logic          clr_done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [AW-1:0] CNT_LAST = '1;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] fill_q, fill_d;
   logic          done_q, done_d;
   logic          rvalid_q;
   logic [AW-1:0] addr_q;

   // State register; the last driven address is kept so an idle port holds it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         fill_q   <= '0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         fill_q   <= fill_d;
         done_q   <= done_d;
         rvalid_q <= disp_req;
         addr_q   <= mem_addr;
      end
   end

   // Port selection (display > clear > host) and clear sequencing; reset
   // forces the port quiet so no write can escape while rst is high
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fill_d    = fill_q;
      done_d    = 1'b0;
      mem_addr  = addr_q;
      mem_we    = 1'b0;
      mem_wdata = '0;
      wr_ready  = 1'b0;
      if (!rst) begin
         wr_ready = (state_q == IDLE) && !disp_req;
         if (disp_req) begin
            mem_addr = disp_addr;
         end else if (state_q == CLEAR) begin
            mem_addr  = cnt_q;
            mem_we    = 1'b1;
            mem_wdata = fill_q;
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end else if (wr_valid) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_data;
         end
         // clr_start is only honoured from IDLE; a pulse during CLEAR is dropped
         if ((state_q == IDLE) && clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
            fill_d  = clr_data;
         end
      end
   end

   // Output mapping; read data is qualified by its valid strobe
   always_comb begin
      disp_rvalid = rvalid_q;
      disp_rdata  = rvalid_q ? mem_rdata : '0;
      clr_busy    = (state_q == CLEAR);
      clr_done    = done_q;
   end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural single-port memory.
module tb_vram_port_arbiter;

   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 2;
   localparam int unsigned DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_rdata;
   logic          disp_rvalid;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          clr_start;
   logic [DW-1:0] clr_data;
   logic          clr_busy;
   logic          clr_done;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem [DEPTH];

   int n_cmp = 0;
   int n_err = 0;

   vram_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .clr_done(clr_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory, 1-cycle read latency
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Stimulus helper: preload every address through the host port
   task automatic host_fill(input logic [DW-1:0] v);
      for (int a = 0; a < DEPTH; a++) begin
         wr_valid = 1'b1; wr_addr = AW'(a); wr_data = v;
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; disp_req = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
      clr_start = 0; clr_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      // write 2'b11 at 5 so the port has a non-zero held address
      wr_valid = 1; wr_addr = 6'd5; wr_data = 2'b11;
      @(posedge clk); #1;
      wr_valid = 0;
      disp_req = 1; disp_addr = 6'd9;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({disp_rvalid, disp_rdata, wr_ready, clr_busy, clr_done, mem_we, mem_addr, mem_wdata} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got rv=%b rd=%h rdy=%b busy=%b done=%b we=%b addr=%0d wd=%h, expected all 0",
                  disp_rvalid, disp_rdata, wr_ready, clr_busy, clr_done, mem_we, mem_addr, mem_wdata);
      end
      disp_req = 0;
      @(posedge clk); #1 rst = 1'b0;
      disp_req = 1; disp_addr = 6'd5;
      @(posedge clk); #1;
      disp_req = 0;
      n_cmp++;
      if (disp_rvalid !== 1'b1 || disp_rdata !== 2'b11) begin
         n_err++;
         $display("FAIL reset_read5: got rv=%b rd=%b expected rv=1 rd=11", disp_rvalid, disp_rdata);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (disp_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL rvalid_single: got %b expected 0", disp_rvalid);
      end
   endtask

   task automatic test_host_write();
      wr_valid = 1; wr_addr = 6'd10; wr_data = 2'b01;
      @(negedge clk);
      n_cmp++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd10 || mem_wdata !== 2'b01) begin
         n_err++;
         $display("FAIL host_write: got rdy=%b we=%b addr=%0d wd=%b expected 1 1 10 01",
                  wr_ready, mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      wr_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0 || mem_addr !== 6'd10) begin
         n_err++;
         $display("FAIL idle_hold: got we=%b addr=%0d expected 0 10", mem_we, mem_addr);
      end
      @(posedge clk); #1;
      disp_req = 1; disp_addr = 6'd10;
      @(posedge clk); #1;
      disp_req = 0;
      n_cmp++;
      if (disp_rvalid !== 1'b1 || disp_rdata !== 2'b01) begin
         n_err++;
         $display("FAIL host_readback: got rv=%b rd=%b expected 1 01", disp_rvalid, disp_rdata);
      end
   endtask

   task automatic test_contention();
      int bad = 0;
      wr_valid = 1; wr_addr = 6'd20; wr_data = 2'b10;
      disp_req = 1;
      for (int i = 0; i < 3; i++) begin
         disp_addr = AW'(3 + i);
         @(negedge clk);
         if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== AW'(3 + i)) bad++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL contention_stall: got %0d bad cycles expected 0", bad);
      end
      disp_req = 0;
      @(negedge clk);
      n_cmp++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd20 || mem_wdata !== 2'b10) begin
         n_err++;
         $display("FAIL contention_release: got rdy=%b we=%b addr=%0d wd=%b expected 1 1 20 10",
                  wr_ready, mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      wr_valid = 0;
      n_cmp++;
      if (mem[20] !== 2'b10) begin
         n_err++;
         $display("FAIL contention_data: got %b expected 10", mem[20]);
      end
   endtask

   task automatic test_clear_plain();
      int busy = 0, done = 0, wseen = 0, bad = 0, memb = 0;
      host_fill(2'b00);
      // clear request and host write in the same idle cycle
      clr_start = 1; clr_data = 2'b10;
      wr_valid = 1; wr_addr = 6'd7; wr_data = 2'b01;
      @(negedge clk);
      n_cmp++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd7 || clr_busy !== 1'b0) begin
         n_err++;
         $display("FAIL start_with_write: got rdy=%b we=%b addr=%0d busy=%b expected 1 1 7 0",
                  wr_ready, mem_we, mem_addr, clr_busy);
      end
      @(posedge clk); #1;
      clr_start = 0; wr_valid = 0;
      n_cmp++;
      if (mem[7] !== 2'b01) begin
         n_err++;
         $display("FAIL simul_host_write: got %b expected 01", mem[7]);
      end
      for (int i = 0; i < 100; i++) begin
         if (clr_busy) busy++;
         if (clr_done) done++;
         @(negedge clk);
         if (mem_we) begin
            if (mem_addr !== AW'(wseen) || mem_wdata !== 2'b10) bad++;
            wseen++;
         end
         @(posedge clk); #1;
      end
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== 2'b10) memb++;
      n_cmp++;
      if (busy != 64) begin n_err++; $display("FAIL clr_busy_len: got %0d expected 64", busy); end
      n_cmp++;
      if (wseen != 64) begin n_err++; $display("FAIL clr_writes: got %0d expected 64", wseen); end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL clr_order: got %0d bad writes expected 0", bad); end
      n_cmp++;
      if (done != 1) begin n_err++; $display("FAIL clr_done_cnt: got %0d expected 1", done); end
      n_cmp++;
      if (memb != 0) begin n_err++; $display("FAIL clr_contents: got %0d wrong cells expected 0", memb); end
   endtask

   task automatic test_clear_alt();
      int i = 0, wseen = 0, bad = 0, rvbad = 0, rdybad = 0, first = -1, last = -1, memb = 0;
      logic done_seen = 1'b0;
      logic req_i;
      clr_start = 1; clr_data = 2'b01;
      @(posedge clk); #1;
      clr_start = 0;
      wr_valid = 1; wr_addr = 6'd40; wr_data = 2'b11;
      while (i < 300 && !done_seen) begin
         req_i = (i % 2 == 0);
         disp_req = req_i; disp_addr = AW'(i);
         clr_start = (i == 30); clr_data = (i == 30) ? 2'b11 : 2'b01;
         @(negedge clk);
         if (wr_ready !== 1'b0) rdybad++;
         if (mem_we) begin
            if (req_i || mem_addr !== AW'(wseen) || mem_wdata !== 2'b01) bad++;
            if (first < 0) first = i;
            last = i;
            wseen++;
         end
         @(posedge clk); #1;
         if (disp_rvalid !== req_i) rvbad++;
         if (clr_done) done_seen = 1'b1;
         i++;
      end
      wr_valid = 0; disp_req = 0; clr_start = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== 2'b01) memb++;
      n_cmp++;
      if (done_seen !== 1'b1) begin n_err++; $display("FAIL alt_timeout: got no clr_done in %0d cycles", i); end
      n_cmp++;
      if (wseen != 64) begin n_err++; $display("FAIL alt_writes: got %0d expected 64", wseen); end
      n_cmp++;
      if (last - first + 1 != 127) begin n_err++; $display("FAIL alt_duration: got %0d expected 127", last - first + 1); end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL alt_order: got %0d bad writes expected 0", bad); end
      n_cmp++;
      if (rvbad != 0) begin n_err++; $display("FAIL alt_rvalid: got %0d bad cycles expected 0", rvbad); end
      n_cmp++;
      if (rdybad != 0) begin n_err++; $display("FAIL alt_wr_ready: got %0d ready cycles expected 0", rdybad); end
      n_cmp++;
      if (memb != 0) begin n_err++; $display("FAIL alt_contents: got %0d wrong cells expected 0", memb); end
      n_cmp++;
      if (clr_busy !== 1'b0) begin n_err++; $display("FAIL alt_busy_end: got %b expected 0", clr_busy); end
   endtask

   task automatic test_reset_mid_clear();
      int done = 0, memb = 0, wseen = 0, i = 0;
      logic done_seen = 1'b0;
      host_fill(2'b11);
      clr_start = 1; clr_data = 2'b00;
      @(posedge clk); #1;
      clr_start = 0;
      repeat (20) begin @(posedge clk); #1; end
      n_cmp++;
      if (clr_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", clr_busy); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0 || mem_we !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got busy=%b done=%b we=%b expected 0 0 0", clr_busy, clr_done, mem_we);
      end
      repeat (2) begin @(posedge clk); #1; if (clr_done) done++; end
      rst = 1'b0;
      repeat (4) begin @(posedge clk); #1; if (clr_done || clr_busy) done++; end
      n_cmp++;
      if (done != 0) begin n_err++; $display("FAIL mid_no_done: got %0d active cycles expected 0", done); end
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== ((a < 20) ? 2'b00 : 2'b11)) memb++;
      n_cmp++;
      if (memb != 0) begin n_err++; $display("FAIL mid_contents: got %0d wrong cells expected 0", memb); end
      clr_start = 1; clr_data = 2'b10;
      @(posedge clk); #1;
      clr_start = 0;
      while (i < 200 && !done_seen) begin
         @(negedge clk);
         if (mem_we) wseen++;
         @(posedge clk); #1;
         if (clr_done) done_seen = 1'b1;
         i++;
      end
      memb = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== 2'b10) memb++;
      n_cmp++;
      if (done_seen !== 1'b1 || wseen != 64) begin
         n_err++;
         $display("FAIL restart_clear: got done=%b writes=%0d expected 1 64", done_seen, wseen);
      end
      n_cmp++;
      if (memb != 0) begin n_err++; $display("FAIL restart_contents: got %0d wrong cells expected 0", memb); end
   endtask

   initial begin
      test_reset();
      test_host_write();
      test_contention();
      test_clear_plain();
      test_clear_alt();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single-port display ROM/RAM (6-bit address, 2-bit data by default) between three requesters:
  - the pixel scan reader, which has fixed priority and fixed latency;
  - a host write port with a valid/ready handshake;
  - an internal clear engine that fills the whole memory with one value.
- Sits between the display scan unit and the block memory, in the pixel clock domain.
- Drives the memory port directly.

Parameters:
AW, 6, memory address width; depth = 2^AW.
DW, 2, memory data width.

Ports:
clk  in  1  pixel clock; all state changes on its rising edge
rst  in  1  asynchronous, active-high reset
disp_req  in  1  scan reader needs a read this cycle
disp_addr  in  AW  scan read address
disp_rdata  out  DW  read data returned to scan reader
disp_rvalid  out  1  disp_rdata valid this cycle
wr_valid  in  1  host write request
wr_addr  in  AW  host write address
wr_data  in  DW  host write data
wr_ready  out  1  host write accepted this cycle when wr_valid=1
clr_start  in  1  one-cycle pulse: begin clear
clr_data  in  DW  fill value, sampled on accepted clr_start
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse after the last clear write
mem_addr  out  AW  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data; valid one cycle after its address

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; clear counter=0; fill register=0.
  - disp_rvalid=0, clr_busy=0, clr_done=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- Port selection is combinational, evaluated each cycle, with fixed priority: display > clear > host.
  - disp_req=1: mem_addr=disp_addr, mem_we=0. disp_rvalid is 1 in the next cycle. disp_rdata=mem_rdata (pass-through). Display latency is always exactly 1 cycle; the scan reader is never stalled.
  - Else if state=CLEAR: mem_addr=counter, mem_we=1, mem_wdata=fill register. The counter increments at the clock edge.
  - Else if state=IDLE and wr_valid=1: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data.
  - Otherwise: mem_we=0 and mem_addr holds its previous value.
- Host handshake:
  - wr_ready = (state==IDLE) && !disp_req. The transfer occurs when wr_valid && wr_ready.
  - wr_ready may depend combinationally on disp_req.
  - The host must hold wr_addr and wr_data stable while wr_valid=1 && wr_ready=0.
  - wr_ready is 0 for the entire CLEAR state.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clr_start=1. Load the fill register with clr_data, set counter=0, assert clr_busy from the next cycle.
  - In CLEAR, the counter advances only on cycles where a clear write was issued (disp_req=0). Cycles stolen by the display leave the counter unchanged.
  - When the write at counter=2^AW−1 is issued: → IDLE, counter=0, clr_busy=0 and clr_done=1 in the next cycle, for 1 cycle.
  - clr_start during CLEAR is ignored; it neither restarts nor extends the clear.
- Simultaneous events:
  - clr_start and wr_valid in the same IDLE cycle with disp_req=0: the host write is accepted that cycle (wr_ready=1), and CLEAR begins the next cycle.
  - Clear writes start on the cycle after clr_start.
- Widths:
  - The counter is AW bits, with terminal compare at all-ones and no wrap past it.
  - Exactly 2^AW clear writes are issued per clear.
- Reset mid-clear: immediate return to IDLE, counter=0, clr_busy=0, and no clr_done pulse.
- Every memory write comes either from the clear engine or from an accepted host write; no other writes are issued.

Test Plan:
- Reset check: assert rst mid-run → all outputs 0 asynchronously. Then issue disp_req=1 with addr=5 and memory contents 2'b11 at 5 → next cycle disp_rvalid=1, disp_rdata=2'b11.
- Host write with disp_req=0: wr_valid=1, addr=10, data=2'b01 → wr_ready=1, mem_we=1, mem_addr=10 in the same cycle. A subsequent display read of 10 returns 2'b01.
- Display contention: hold wr_valid=1 while disp_req=1 for 3 cycles → wr_ready=0 and mem_we=0 for those 3 cycles. The write completes on the first cycle disp_req=0, and the data is unchanged.
- Clear with no display traffic: clr_start with clr_data=2'b10 → clr_busy high for exactly 64 cycles and 64 writes to addresses 0..63. clr_done pulses once, and every address reads back 2'b10.
- Clear with disp_req asserted on alternate cycles: exactly 64 clear writes, duration 127 cycles (first to last write). Display reads all get disp_rvalid one cycle later. A second clr_start issued mid-clear has no effect, and wr_ready=0 throughout.
- Reset at counter=20 during a clear → clr_busy=0 with no clr_done pulse. Addresses 0..19 hold the fill value and 20..63 keep their old data. A new clr_start completes normally.
